wb_arbiter: RTL and testbench

Write-back arbiter that drives the register file's single write port (`writereg`/`writedata`/`RegWrite`) from two result sources:
- a single-cycle ALU path that cannot be stalled downstream;
- a long-latency path (loads, mul/div) that uses a valid/ready handshake and is buffered in a small FIFO.

It sits between the execute/memory stages and the register file. It publishes a pending-write scoreboard for the hazard unit.

---
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU and long-latency result inputs, register-file write port
// and hazard-unit status. The slave modport is the arbiter's side.
interface wb_arbiter_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             alu_valid;
   logic [4:0]       alu_reg;
   logic [31:0]      alu_data;
   logic             mem_valid;
   logic [4:0]       mem_reg;
   logic [31:0]      mem_data;
   logic             mem_ready;
   logic [4:0]       writereg;
   logic [31:0]      writedata;
   logic             RegWrite;
   logic             alu_stall;
   logic [31:0]      busy_mask;
   logic [CNT_W-1:0] fifo_count;
   logic             err;

   modport master (
      output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
      input  mem_ready, writereg, writedata, RegWrite, alu_stall, busy_mask, fifo_count, err
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
      output mem_ready, writereg, writedata, RegWrite, alu_stall, busy_mask, fifo_count, err
   );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: unstallable ALU results versus a FIFO of
// long-latency results, with a starvation limit and a pending-write scoreboard.
module wb_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   wb_arbiter_if.slave    bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

   logic [4:0]       r_fifo_reg  [FIFO_DEPTH];
   logic [31:0]      r_fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [STV_W-1:0] r_starve;
   logic [4:0]       r_writereg;
   logic [31:0]      r_writedata;
   logic             r_regwrite;
   logic             r_err;

   logic             w_nonempty;
   logic             w_stall;
   logic             w_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_alu_win;
   logic             w_err_set;
   logic [31:0]      w_fifo_mask;
   logic [CNT_W-1:0] w_count_nxt;
   logic [STV_W-1:0] w_starve_nxt;

   function automatic logic [31:0] onehot32(input logic [4:0] reg_idx);
      onehot32 = 32'd1 << reg_idx;
   endfunction

   assign w_nonempty = (r_count != {CNT_W{1'b0}});
   assign w_stall    = (r_starve >= LIMIT_C);
   // Ready is forced low during reset; no full-bypass even when a pop is pending.
   assign w_ready    = rst_n && (r_count < DEPTH_C);
   assign w_push     = bus.mem_valid && w_ready && (bus.mem_reg != 5'd0);

   // Registers targeted by entries currently held in the FIFO
   always_comb begin
      logic [PTR_W-1:0] v_off;
      v_off       = {PTR_W{1'b0}};
      w_fifo_mask = 32'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         v_off       = PTR_W'(i) - r_rd_ptr;
         w_fifo_mask = w_fifo_mask |
                       (({1'b0, v_off} < r_count) ? onehot32(r_fifo_reg[i]) : 32'd0);
      end
   end

   // Write-port winner selection
   always_comb begin
      w_pop     = 1'b0;
      w_alu_win = 1'b0;
      if (w_stall && w_nonempty) begin
         w_pop = 1'b1;
      end else if (bus.alu_valid && (bus.alu_reg != 5'd0)) begin
         w_alu_win = 1'b1;
      end else if (w_nonempty) begin
         w_pop = 1'b1;
      end else begin
         w_pop     = 1'b0;
         w_alu_win = 1'b0;
      end
   end

   assign w_err_set = bus.alu_valid &&
                      (w_stall || ((bus.alu_reg != 5'd0) && w_fifo_mask[bus.alu_reg]));

   // Next occupancy and starvation count
   always_comb begin
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
      if (w_pop || !w_nonempty) begin
         w_starve_nxt = {STV_W{1'b0}};
      end else if (r_starve < LIMIT_C) begin
         w_starve_nxt = r_starve + STV_W'(1);
      end else begin
         w_starve_nxt = r_starve;
      end
   end

   // FIFO control state and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
         r_starve <= {STV_W{1'b0}};
         r_err    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count  <= w_count_nxt;
         r_starve <= w_starve_nxt;
         r_err    <= r_err || w_err_set;
      end
   end

   // FIFO payload storage; validity comes from the pointers, so no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_reg[r_wr_ptr]  <= bus.mem_reg;
         r_fifo_data[r_wr_ptr] <= bus.mem_data;
      end
   end

   // Output stage: address/data hold when nothing wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regwrite  <= 1'b0;
         r_writereg  <= 5'd0;
         r_writedata <= 32'd0;
      end else if (w_alu_win) begin
         r_regwrite  <= 1'b1;
         r_writereg  <= bus.alu_reg;
         r_writedata <= bus.alu_data;
      end else if (w_pop) begin
         r_regwrite  <= 1'b1;
         r_writereg  <= r_fifo_reg[r_rd_ptr];
         r_writedata <= r_fifo_data[r_rd_ptr];
      end else begin
         r_regwrite  <= 1'b0;
      end
   end

   assign bus.mem_ready  = w_ready;
   assign bus.alu_stall  = w_stall;
   assign bus.writereg   = r_writereg;
   assign bus.writedata  = r_writedata;
   assign bus.RegWrite   = r_regwrite;
   assign bus.fifo_count = r_count;
   assign bus.err        = r_err;
   assign bus.busy_mask  = (w_fifo_mask | (r_regwrite ? onehot32(r_writereg) : 32'd0)) & ~32'd1;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the write-back rules.
module tb_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int LIMIT = 4;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ent_t        m_q[$];
   int          m_starve;
   logic        m_we;
   logic [4:0]  m_wr;
   logic [31:0] m_wd;
   logic        m_err;

   always #5 clk = ~clk;

   wb_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

   wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] m;
      m = 32'd0;
      foreach (m_q[i]) m = m | (32'd1 << m_q[i].r);
      if (m_we) m = m | (32'd1 << m_wr);
      return m & ~32'd1;
   endfunction

   task automatic check_all();
      check("RegWrite",   32'(bus.RegWrite),   32'(m_we));
      check("writereg",   32'(bus.writereg),   32'(m_wr));
      check("writedata",  bus.writedata,       m_wd);
      check("mem_ready",  32'(bus.mem_ready),  32'((rst_n === 1'b1) && (m_q.size() < DEPTH)));
      check("alu_stall",  32'(bus.alu_stall),  32'(m_starve >= LIMIT));
      check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
      check("busy_mask",  bus.busy_mask,       model_busy());
      check("err",        32'(bus.err),        32'(m_err));
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0;
      bus.alu_reg   = 5'd0;
      bus.alu_data  = 32'd0;
      bus.mem_valid = 1'b0;
      bus.mem_reg   = 5'd0;
      bus.mem_data  = 32'd0;
   endtask

   // One clock: decide from the rules with pre-edge state, then compare after the edge
   task automatic cycle();
      bit          stall, nonempty, pop, aluwin, hit, push;
      ent_t        head, ne;
      int          starve_n;
      stall    = (m_starve >= LIMIT);
      nonempty = (m_q.size() != 0);
      pop      = 1'b0;
      aluwin   = 1'b0;
      if (stall && nonempty) pop = 1'b1;
      else if (bus.alu_valid && bus.alu_reg != 5'd0) aluwin = 1'b1;
      else if (nonempty) pop = 1'b1;
      hit = 1'b0;
      foreach (m_q[i]) if (m_q[i].r == bus.alu_reg) hit = 1'b1;
      push = bus.mem_valid && (m_q.size() < DEPTH) && (bus.mem_reg != 5'd0);
      ne.r = bus.mem_reg;
      ne.d = bus.mem_data;
      if (pop || !nonempty) starve_n = 0;
      else starve_n = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      if (bus.alu_valid && (stall || (bus.alu_reg != 5'd0 && hit))) m_err = 1'b1;
      if (aluwin) begin
         m_we = 1'b1; m_wr = bus.alu_reg; m_wd = bus.alu_data;
      end else if (pop) begin
         head = m_q[0];
         m_we = 1'b1; m_wr = head.r; m_wd = head.d;
      end else begin
         m_we = 1'b0;
      end
      @(posedge clk);
      #1;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(ne);
      m_starve = starve_n;
      check_all();
   endtask

   task automatic do_reset();
      idle_inputs();
      #2;
      rst_n = 1'b0;
      m_q.delete();
      m_starve = 0;
      m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_err = 1'b0;
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      #1;
      check_all();
   endtask

   initial begin
      idle_inputs();
      m_q.delete();
      m_starve = 0;
      m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_err = 1'b0;
      #3;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("ready_after_reset", 32'(bus.mem_ready), 32'd1);
      for (int i = 0; i < 10; i++) cycle();

      // ALU only: r5, r6, then r0 which must not write
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'h11;
      cycle();
      check("alu_r5_addr", 32'(bus.writereg), 32'd5);
      check("alu_r5_data", bus.writedata, 32'h11);
      bus.alu_reg = 5'd6; bus.alu_data = 32'h22;
      cycle();
      check("alu_r6_data", bus.writedata, 32'h22);
      bus.alu_reg = 5'd0; bus.alu_data = 32'h33;
      cycle();
      check("alu_r0_nowrite", 32'(bus.RegWrite), 32'd0);
      idle_inputs();
      cycle();

      // Fill the FIFO behind ALU traffic, then drain in order
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1; bus.alu_reg = 5'(20 + i); bus.alu_data = 32'(i);
         bus.mem_valid = 1'b1; bus.mem_reg = 5'(1 + i);  bus.mem_data = 32'h100 + 32'(i);
         cycle();
      end
      check("fill_count", 32'(bus.fifo_count), 32'd4);
      check("fill_ready_low", 32'(bus.mem_ready), 32'd0);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("drain_order", 32'(bus.writereg), 32'(1 + i));
      end
      cycle();
      check("drain_busy_clear", bus.busy_mask, 32'd0);

      // Starvation: one r9 entry under continuous ALU traffic
      do_reset();
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'h1;
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd9; bus.mem_data = 32'hABCD;
      cycle();
      bus.mem_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         bus.alu_reg = 5'(2 + j); bus.alu_data = 32'(2 + j);
         cycle();
      end
      check("starve_stall", 32'(bus.alu_stall), 32'd1);
      bus.alu_reg = 5'd6; bus.alu_data = 32'h6;
      cycle();
      check("forced_reg", 32'(bus.writereg), 32'd9);
      check("forced_data", bus.writedata, 32'hABCD);
      check("stall_cleared", 32'(bus.alu_stall), 32'd0);
      check("err_on_stall", 32'(bus.err), 32'd1);
      idle_inputs();
      for (int i = 0; i < 3; i++) cycle();
      check("err_sticky", 32'(bus.err), 32'd1);
      do_reset();
      check("err_cleared", 32'(bus.err), 32'd0);

      // WAW: ALU r7 while r7 is pending in the FIFO
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h3;
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd7; bus.mem_data = 32'h77;
      cycle();
      bus.mem_valid = 1'b0;
      bus.alu_reg = 5'd7; bus.alu_data = 32'h7A;
      cycle();
      check("waw_alu_first", bus.writedata, 32'h7A);
      check("waw_err", 32'(bus.err), 32'd1);
      idle_inputs();
      cycle();
      check("waw_fifo_reg", 32'(bus.writereg), 32'd7);
      check("waw_fifo_data", bus.writedata, 32'h77);

      // Random traffic with periodic resets
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if (n % 300 == 299) do_reset();
         bus.alu_valid = ($urandom_range(0, 15) == 0) ||
                         (($urandom_range(0, 2) != 0) && (m_starve < LIMIT));
         bus.alu_reg   = 5'($urandom_range(0, 31));
         bus.alu_data  = $urandom;
         bus.mem_valid = 1'($urandom_range(0, 1));
         bus.mem_reg   = 5'($urandom_range(0, 31));
         bus.mem_data  = $urandom;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
